mul_share_sched: RTL

- Schedules one shared pipelined 12x12 carry-save multiplier (partial-product/compressor tree plus final adder) between two requesters in a PE: requester 0 is the NTT butterfly, requester 1 is pointwise multiply.
- Arbitrates round-robin and drives the multiplier operands.
- Tracks the owner of each in-flight product with a tag pipeline, then steers each result into a per-requester response FIFO.
- Uses credit-based issue so the fixed-latency multiplier never needs to stall.

---
 rtl/mul_share_sched.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mul_share_sched.sv
// Round-robin scheduler for one shared fixed-latency multiplier. Issue is credit-based,
// a tag pipeline tracks result ownership, and results go to per-requester response FIFOs.

module mul_share_lane #(
  parameter int DW    = 24,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          i_issue,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rdy,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_cr_nz,
  output logic          o_busy
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]            r_cr;
  logic [PW-1:0]            r_wp, r_rp;
  logic [DEPTH-1:0][DW-1:0] r_mem;
  logic                     w_empty, w_full, w_pop, w_wr;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[PW-1] != r_rp[PW-1]) && (r_wp[PW-2:0] == r_rp[PW-2:0]);
  assign w_pop   = !w_empty && i_rdy;
  assign w_wr    = i_wr && !w_full;

  // Credits cover both in-flight products and buffered results, so a slot is
  // reserved at issue and only returned when the requester pops it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cr  <= CW'(DEPTH);
      r_wp  <= '0;
      r_rp  <= '0;
      r_mem <= '0;
    end else if (clr) begin
      r_cr  <= CW'(DEPTH);
      r_wp  <= '0;
      r_rp  <= '0;
      r_mem <= '0;
    end else begin
      if (i_issue && !w_pop)      r_cr <= r_cr - CW'(1);
      else if (!i_issue && w_pop) r_cr <= r_cr + CW'(1);
      if (w_wr) begin
        r_mem[r_wp[PW-2:0]] <= i_wdata;
        r_wp                <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
    end
  end

  assign o_valid = !w_empty;
  assign o_data  = r_mem[r_rp[PW-2:0]];
  assign o_cr_nz = (r_cr != '0);
  assign o_busy  = (r_cr != CW'(DEPTH));
endmodule

module mul_share_sched #(
  parameter int DATA_W     = 12,
  parameter int MUL_LAT    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_W-1:0]   req0_a,
  input  logic [DATA_W-1:0]   req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_W-1:0]   req1_a,
  input  logic [DATA_W-1:0]   req1_b,
  output logic                mul_vld,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  input  logic [2*DATA_W-1:0] mul_p,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [2*DATA_W-1:0] rsp0_data,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [2*DATA_W-1:0] rsp1_data,
  output logic                busy
);
  localparam int PW = 2 * DATA_W;

  logic [1:0]           w_req_vld, w_elig, w_gnt, w_cr_nz, w_busy, w_rsp_vld, w_rsp_rdy, w_wr;
  logic [1:0][PW-1:0]   w_rsp_data;
  logic                 w_en;
  logic                 r_last;
  logic [MUL_LAT:0]     r_vld_pipe;
  logic [MUL_LAT:0]     r_tag_pipe;
  logic [DATA_W-1:0]    r_mul_a, r_mul_b;

  assign w_req_vld = {req1_valid, req0_valid};
  assign w_rsp_rdy = {rsp1_ready, rsp0_ready};
  assign w_elig    = w_req_vld & w_cr_nz;
  // Grants are suppressed while reset or clr is active so no handshake is lost.
  assign w_en      = reset && !clr;
  assign w_gnt[0]  = w_en && w_elig[0] && (!w_elig[1] || r_last);
  assign w_gnt[1]  = w_en && w_elig[1] && (!w_elig[0] || !r_last);

  // Stage 0 lines up with mul_vld; stage MUL_LAT lines up with the product on mul_p.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last     <= 1'b1;
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
    end else if (clr) begin
      r_last     <= 1'b1;
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[MUL_LAT-1:0], |w_gnt};
      r_tag_pipe <= {r_tag_pipe[MUL_LAT-1:0], w_gnt[1]};
      if (|w_gnt) begin
        r_last  <= w_gnt[1];
        r_mul_a <= w_gnt[1] ? req1_a : req0_a;
        r_mul_b <= w_gnt[1] ? req1_b : req0_b;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_lane
    assign w_wr[g] = r_vld_pipe[MUL_LAT] && (r_tag_pipe[MUL_LAT] == 1'(g));
    mul_share_lane #(.DW(PW), .DEPTH(FIFO_DEPTH)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .i_issue (w_gnt[g]),
      .i_wr    (w_wr[g]),
      .i_wdata (mul_p),
      .i_rdy   (w_rsp_rdy[g]),
      .o_valid (w_rsp_vld[g]),
      .o_data  (w_rsp_data[g]),
      .o_cr_nz (w_cr_nz[g]),
      .o_busy  (w_busy[g])
    );
  end

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign mul_vld    = r_vld_pipe[0];
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign rsp0_valid = w_rsp_vld[0];
  assign rsp0_data  = w_rsp_data[0];
  assign rsp1_valid = w_rsp_vld[1];
  assign rsp1_data  = w_rsp_data[1];
  assign busy       = |w_busy;
endmodule
